// File: rtl/eyearch_cpu_if.sv
// Program ROM port: the core drives the fetch address, the ROM returns the word combinationally.
interface eyearch_cpu_if #(
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned INSTR_W = 32
);
   logic [ADDR_W-1:0]  prom_addr;
   logic [INSTR_W-1:0] instruction;

   modport master (output prom_addr, input instruction);
   modport slave  (input prom_addr, output instruction);
endinterface

// File: rtl/eyearch_cpu.sv
// Single-cycle 16-bit register CPU: fetch, execute and retire one instruction per clock.
module eyearch_cpu #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned NREGS  = 32
) (
   input  logic              clk,
   input  logic              rst,
   eyearch_cpu_if.master     prom
);
   localparam int unsigned RIDX_W = $clog2(NREGS);
   localparam int unsigned SHAM_W = $clog2(DATA_W);

   localparam logic [5:0] OP_ADDI = 6'h01;
   localparam logic [5:0] OP_SUBI = 6'h02;
   localparam logic [5:0] OP_ANDI = 6'h03;
   localparam logic [5:0] OP_ORI  = 6'h04;
   localparam logic [5:0] OP_XORI = 6'h05;
   localparam logic [5:0] OP_SHLI = 6'h06;
   localparam logic [5:0] OP_SHRI = 6'h07;
   localparam logic [5:0] OP_LDI  = 6'h0E;
   localparam logic [5:0] OP_JMP  = 6'h10;
   localparam logic [5:0] OP_JZ   = 6'h11;
   localparam logic [5:0] OP_JNZ  = 6'h12;
   localparam logic [5:0] OP_JC   = 6'h13;

   // Architectural state; regs/z_flag/c_flag keep these names for hierarchical inspection
   logic [DATA_W-1:0] regs [NREGS];
   logic              z_flag;
   logic              c_flag;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_d;
   logic              z_d;
   logic              c_d;

   // Decoded fields
   logic [5:0]        opcode;
   logic [RIDX_W-1:0] rs;
   logic [RIDX_W-1:0] rd;
   logic [DATA_W-1:0] imm;
   logic [DATA_W-1:0] rs_val;
   logic [DATA_W-1:0] result;
   logic              wr_en;
   logic [DATA_W:0]   sum_ext;

   assign opcode = prom.instruction[5:0];
   assign rs     = prom.instruction[10:6];
   assign rd     = prom.instruction[15:11];
   assign imm    = prom.instruction[31:16];

   // r0 is hardwired to zero on the read side
   assign rs_val  = (rs == '0) ? '0 : regs[rs];
   assign sum_ext = {1'b0, rs_val} + {1'b0, imm};

   assign prom.prom_addr = pc_q;

   // Next-state decode: result, register write enable, flags and PC
   always_comb begin
      pc_d   = pc_q + ADDR_W'(1);
      z_d    = z_flag;
      c_d    = c_flag;
      result = '0;
      wr_en  = 1'b0;
      unique case (opcode)
         OP_ADDI: begin result = sum_ext[DATA_W-1:0]; c_d = sum_ext[DATA_W]; wr_en = 1'b1; end
         OP_SUBI: begin result = rs_val - imm; c_d = (rs_val < imm); wr_en = 1'b1; end
         OP_ANDI: begin result = rs_val & imm; c_d = 1'b0; wr_en = 1'b1; end
         OP_ORI:  begin result = rs_val | imm; c_d = 1'b0; wr_en = 1'b1; end
         OP_XORI: begin result = rs_val ^ imm; c_d = 1'b0; wr_en = 1'b1; end
         OP_SHLI: begin result = rs_val << imm[SHAM_W-1:0]; c_d = 1'b0; wr_en = 1'b1; end
         OP_SHRI: begin result = rs_val >> imm[SHAM_W-1:0]; c_d = 1'b0; wr_en = 1'b1; end
         OP_LDI:  begin result = imm; wr_en = 1'b1; end
         OP_JMP:  pc_d = ADDR_W'(imm);
         OP_JZ:   if (z_flag)  pc_d = ADDR_W'(imm);
         OP_JNZ:  if (!z_flag) pc_d = ADDR_W'(imm);
         OP_JC:   if (c_flag)  pc_d = ADDR_W'(imm);
         default: ;
      endcase
      // Zero flag only tracks ALU ops, not LDI
      if (opcode >= OP_ADDI && opcode <= OP_SHRI) begin
         z_d = (result == '0);
      end
   end

   // State update; reset overrides any instruction on the bus
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q   <= '0;
         z_flag <= 1'b0;
         c_flag <= 1'b0;
         for (int i = 0; i < int'(NREGS); i++) begin
            regs[i] <= '0;
         end
      end else begin
         pc_q   <= pc_d;
         z_flag <= z_d;
         c_flag <= c_d;
         if (wr_en && rd != '0) begin
            regs[rd] <= result;
         end
      end
   end
endmodule

// File: tb/tb_eyearch_cpu.sv
// Randomized scoreboard bench for eyearch_cpu against an arithmetic reference model.
module tb_eyearch_cpu;
   logic clk = 1'b0;
   logic rst;

   eyearch_cpu_if bus ();

   eyearch_cpu dut (
      .clk  (clk),
      .rst  (rst),
      .prom (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int    pc;
      int    z;
      int    c;
      int    idx;
      int    val;
   } exp_t;

   exp_t exp_q [$];
   int   checks   = 0;
   int   failures = 0;

   // Reference architectural state
   int m_regs [32];
   int m_pc;
   int m_z;
   int m_c;

   task automatic chk(input string nm, input int act, input int expv);
      checks++;
      if (act != expv) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
      end
   endtask

   function automatic logic [31:0] enc(input int op, input int rs, input int rd, input int imm);
      logic [31:0] w;
      w = {imm[15:0], rd[4:0], rs[4:0], op[5:0]};
      return w;
   endfunction

   // Apply one instruction (or reset) to the model and issue it to the DUT
   task automatic step(input bit r, input logic [31:0] ins);
      int op, rs, rd, imm, a, res, sh;
      bit alu, wr;
      exp_t e;
      @(negedge clk);
      rst = r;
      bus.instruction = ins;
      op  = int'(ins[5:0]);
      rs  = int'(ins[10:6]);
      rd  = int'(ins[15:11]);
      imm = int'(ins[31:16]);
      sh  = imm % 16;
      if (r) begin
         foreach (m_regs[i]) m_regs[i] = 0;
         m_pc = 0; m_z = 0; m_c = 0;
      end else begin
         a   = m_regs[rs];
         res = 0; alu = 1; wr = 1;
         m_pc = (m_pc + 1) % 65536;
         case (op)
            1: begin res = a + imm; m_c = (res > 65535); res = res % 65536; end
            2: begin m_c = (a < imm); res = (a - imm + 65536) % 65536; end
            3: begin res = a & imm; m_c = 0; end
            4: begin res = a | imm; m_c = 0; end
            5: begin res = a ^ imm; m_c = 0; end
            6: begin res = (a * (1 << sh)) % 65536; m_c = 0; end
            7: begin res = a / (1 << sh); m_c = 0; end
            14: begin res = imm; alu = 0; end
            default: begin
               alu = 0; wr = 0;
               if (op == 16 || (op == 17 && m_z == 1) || (op == 18 && m_z == 0) ||
                   (op == 19 && m_c == 1))
                  m_pc = imm;
            end
         endcase
         if (alu) m_z = (res == 0);
         if (wr && rd != 0) m_regs[rd] = res;
      end
      e.pc  = m_pc;
      e.z   = m_z;
      e.c   = m_c;
      e.idx = r ? int'($urandom_range(31)) : rd;
      e.val = m_regs[e.idx];
      exp_q.push_back(e);
   endtask

   // Sync point for directed constant checks: just after the last issued instruction retires
   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   // Monitor: every retired instruction is compared with the oldest expectation
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("prom_addr", int'(bus.prom_addr), e.pc);
            chk("z_flag", int'(dut.z_flag), e.z);
            chk("c_flag", int'(dut.c_flag), e.c);
            chk($sformatf("r%0d", e.idx), int'(dut.regs[e.idx]), e.val);
         end
      end
   end

   initial begin
      int op;
      int ops [14] = '{0, 1, 2, 3, 4, 5, 6, 7, 14, 16, 17, 18, 19, 9};
      logic [31:0] w;
      rst = 1'b1;
      bus.instruction = '0;

      // Reset then free-running NOPs
      step(1, enc(16, 0, 0, 16'h1234));
      settle();
      chk("rst_pc", int'(bus.prom_addr), 0);
      chk("rst_r5", int'(dut.regs[5]), 0);
      step(0, 32'h0); step(0, 32'h0); step(0, 32'h0);
      settle();
      chk("pc_after_3", int'(bus.prom_addr), 3);

      // Directed program
      step(1, 32'h0);
      step(0, 32'h0003080E); step(0, 32'h0007100E); step(0, 32'h00031041);
      step(0, 32'h00071042);
      settle();
      chk("subi_r2", int'(dut.regs[2]), 16'hFFFC);
      chk("subi_c", int'(dut.c_flag), 1);
      step(0, 32'h00081045);
      settle();
      chk("xori_r2", int'(dut.regs[2]), 16'h000B);
      chk("seq_pc", int'(bus.prom_addr), 5);

      // Carry/zero wrap then taken JZ
      step(0, enc(1, 0, 1, 16'hFFFF)); step(0, enc(1, 1, 1, 1));
      settle();
      chk("wrap_r1", int'(dut.regs[1]), 0);
      chk("wrap_z", int'(dut.z_flag), 1);
      chk("wrap_c", int'(dut.c_flag), 1);
      step(0, enc(17, 0, 0, 16'h0040));
      settle();
      chk("jz_pc", int'(bus.prom_addr), 16'h0040);

      // PC wrap
      step(0, enc(16, 0, 0, 16'hFFFF));
      step(0, 32'h0);
      settle();
      chk("pc_wrap", int'(bus.prom_addr), 0);

      // r0 immunity
      step(0, enc(14, 0, 0, 5)); step(0, enc(1, 0, 3, 0));
      settle();
      chk("r0_zero", int'(dut.regs[0]), 0);
      chk("r3_zero", int'(dut.regs[3]), 0);
      chk("r0_z", int'(dut.z_flag), 1);

      // Reset mid-program with a JMP on the bus
      step(1, enc(16, 0, 0, 16'h0100));
      settle();
      chk("midrst_pc", int'(bus.prom_addr), 0);
      chk("midrst_r1", int'(dut.regs[1]), 0);

      // Random programs
      for (int n = 0; n < 600; n++) begin
         op = ops[$urandom_range(13)];
         if (op == 9) op = int'($urandom_range(63));
         w = $urandom;
         w[5:0] = op[5:0];
         if ($urandom_range(7) == 0) w[31:16] = ($urandom_range(1) != 0) ? 16'hFFFF : 16'h0000;
         step(($urandom_range(49) == 0), w);
      end

      repeat (3) @(posedge clk);
      #3;
      chk("queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
